// File: rtl/bus_uart.sv
// 8N1 UART peripheral on the 16-bit 68000-style bus: tx holding path, single-byte rx buffer, status word.
// Optional internal loopback (control register, addr 2) is compiled in with `define UART_LOOPBACK_EN.
module bus_uart #(
  parameter int SYS_CLK  = 12_500_000,
  parameter int BAUDRATE = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  input  logic [1:0]  addr,
  input  logic        rw,
  input  logic        uds,
  input  logic        lds,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  output logic        ack,
  output logic        tx_active,
  output logic        rx_avail,
  input  logic        rx_avail_clear_i
);

  localparam int DIV   = SYS_CLK / BAUDRATE;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic strobe;
  logic accept;
  logic ack_q, ack_d;
  logic rd_rx;
  logic wr_tx;

  state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bits_q, tx_bits_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_ser_q, tx_ser_d;

  state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bits_q, rx_bits_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  logic              rx_src;
  logic              rx_done;

  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_avail_q, rx_avail_d;
  logic              overrun_q, overrun_d;
  logic              framing_q, framing_d;

  logic              unused_bits;
  assign unused_bits = &{1'b0, data_write[15:8]};

`ifdef UART_LOOPBACK_EN
  logic loopback_q, loopback_d;
  assign rx_src = loopback_q ? tx_ser_q : rx;
  assign tx     = loopback_q ? 1'b1 : tx_ser_q;
`else
  assign rx_src = rx;
  assign tx     = tx_ser_q;
`endif

  // Bus handshake: one accepted action per strobe assertion
  assign strobe    = uds | lds;
  assign ack_d     = strobe;
  assign ack       = ack_q;
  assign accept    = strobe & ~ack_q;
  assign tx_active = (tx_state_q != IDLE);
  assign rx_avail  = rx_avail_q;
  assign rd_rx     = accept & rw & (addr == 2'd1);
  assign wr_tx     = accept & ~rw & (addr == 2'd3) & lds & ~tx_active;

`ifdef UART_LOOPBACK_EN
  always_comb begin
    loopback_d = loopback_q;
    if (accept && !rw && addr == 2'd2 && lds) loopback_d = data_write[0];
  end
`endif

  always_comb begin
    data_read = 16'h0000;
    if (rw && strobe) begin
      case (addr)
        2'd0: data_read = {12'h000, framing_q, overrun_q, rx_avail_q, tx_active};
        2'd1: data_read = {8'h00, rx_data_q};
        2'd2: begin
`ifdef UART_LOOPBACK_EN
          data_read = {15'b0, loopback_q};
`endif
        end
        default: data_read = 16'h0000;
      endcase
    end
  end

  // Transmitter FSM
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_ser_d   = tx_ser_q;
    case (tx_state_q)
      IDLE: begin
        tx_ser_d = 1'b1;
        if (wr_tx) begin
          tx_state_d = START;
          tx_cnt_d   = '0;
          tx_shift_d = data_write[7:0];
          tx_ser_d   = 1'b0;
        end
      end
      START: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_state_d = DATA;
          tx_cnt_d   = '0;
          tx_bits_d  = 3'd0;
          tx_ser_d   = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          if (tx_bits_q == 3'd7) begin
            tx_state_d = STOP;
            tx_ser_d   = 1'b1;
          end else begin
            tx_bits_d  = tx_bits_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_ser_d   = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_state_d = IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Receiver FSM: start bit checked at half period, later bits at mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = START;
          rx_cnt_d   = '0;
        end
      end
      START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bits_d  = 3'd0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bits_q == 3'd7) rx_state_d = STOP;
          else rx_bits_d = rx_bits_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = IDLE;
          rx_done    = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // A completing byte takes priority over a concurrent rx-data read
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_avail_d = rx_avail_q;
    overrun_d  = overrun_q;
    framing_d  = framing_q;
    if (rd_rx) begin
      rx_avail_d = 1'b0;
      overrun_d  = 1'b0;
      framing_d  = 1'b0;
    end
    if (rx_done) begin
      rx_data_d  = rx_shift_q;
      rx_avail_d = 1'b1;
      if (rx_avail_q && !rd_rx) overrun_d = 1'b1;
      if (!rx_sync_q) framing_d = 1'b1;
    end
    if (rx_avail_clear_i) rx_avail_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q      <= 1'b0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bits_q  <= 3'd0;
      tx_ser_q   <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bits_q  <= 3'd0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_avail_q <= 1'b0;
      overrun_q  <= 1'b0;
      framing_q  <= 1'b0;
`ifdef UART_LOOPBACK_EN
      loopback_q <= 1'b0;
`endif
    end else begin
      ack_q      <= ack_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bits_q  <= tx_bits_d;
      tx_ser_q   <= tx_ser_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bits_q  <= rx_bits_d;
      rx_meta_q  <= rx_src;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_data_q  <= rx_data_d;
      rx_avail_q <= rx_avail_d;
      overrun_q  <= overrun_d;
      framing_q  <= framing_d;
`ifdef UART_LOOPBACK_EN
      loopback_q <= loopback_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

endmodule

// File: tb/tb_bus_uart.sv
// Bench for bus_uart: table-driven tx/rx frames plus directed corner-case sequences.
module tb_bus_uart;
  localparam int DIV = 108;

  logic        clk = 1'b0;
  logic        reset, rx, tx, rw, uds, lds, ack, tx_active, rx_avail, rx_avail_clear_i;
  logic [1:0]  addr;
  logic [15:0] data_write, data_read;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_uart dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .addr(addr), .rw(rw),
    .uds(uds), .lds(lds), .data_write(data_write), .data_read(data_read),
    .ack(ack), .tx_active(tx_active), .rx_avail(rx_avail),
    .rx_avail_clear_i(rx_avail_clear_i)
  );

  typedef struct {
    logic [7:0] b;
    logic [9:0] frame;
  } tx_vec_t;

  typedef struct {
    logic [7:0]  b;
    logic        stop;
    logic [15:0] st;
    logic [15:0] dat;
  } rx_vec_t;

  tx_vec_t tv[4];
  rx_vec_t rv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; rw = 1'b1; uds = 1'b1; lds = 1'b1;
    #1 d = data_read;
    @(negedge clk);
    uds = 1'b0; lds = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic u, input logic l, input logic [15:0] d);
    @(negedge clk);
    addr = a; rw = 1'b0; uds = u; lds = l; data_write = d;
    @(negedge clk);
    uds = 1'b0; lds = 1'b0; rw = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  initial begin
    logic [15:0] rd;
    int          active_cnt;
    logic        seen;
    logic        tog;
    int          cnt;

    // frame bit i = i-th serial bit: start(0), d0..d7, stop(1)
    tv[0] = '{b: 8'h41, frame: 10'h282};
    tv[1] = '{b: 8'hA5, frame: 10'h34A};
    tv[2] = '{b: 8'h00, frame: 10'h200};
    tv[3] = '{b: 8'hFF, frame: 10'h3FE};

    rv[0] = '{b: 8'h5A, stop: 1'b1, st: 16'h0002, dat: 16'h005A};
    rv[1] = '{b: 8'h00, stop: 1'b0, st: 16'h000A, dat: 16'h0000};
    rv[2] = '{b: 8'hFF, stop: 1'b1, st: 16'h0002, dat: 16'h00FF};
    rv[3] = '{b: 8'h81, stop: 1'b0, st: 16'h000A, dat: 16'h0081};

    reset = 1'b1; rx = 1'b1; rx_avail_clear_i = 1'b0;
    addr = 2'd0; rw = 1'b1; uds = 1'b0; lds = 1'b0; data_write = 16'h0000;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ack", ack, 1'b0);
    check("rst_tx_active", tx_active, 1'b0);
    check("rst_rx_avail", rx_avail, 1'b0);
    check("rst_data_read_idle", data_read, 16'h0000);
    bus_read(2'd0, rd);
    check("rst_status", rd, 16'h0000);
    bus_read(2'd1, rd);
    check("rst_rx_data", rd, 16'h0000);

`ifdef UART_LOOPBACK_EN
    bus_write(2'd2, 1'b0, 1'b1, 16'h0001);
    bus_read(2'd2, rd);
    check("lb_ctrl_read", rd, 16'h0001);
    bus_write(2'd3, 1'b0, 1'b1, 16'h00A5);
    seen = 1'b0;
    for (int n = 0; n < 10 * DIV + 20; n++) begin
      @(negedge clk);
      if (tx !== 1'b1) seen = 1'b1;
    end
    check("lb_tx_pin_high", seen, 1'b0);
    bus_read(2'd1, rd);
    check("lb_rx_data", rd, 16'h00A5);
    bus_write(2'd2, 1'b0, 1'b1, 16'h0000);
`else
    bus_write(2'd2, 1'b0, 1'b1, 16'h0001);
    bus_read(2'd2, rd);
    check("ctrl_read_zero", rd, 16'h0000);
`endif

    // Transmit frames; a second write lands mid-frame and must be dropped
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = 2'd3; rw = 1'b0; uds = 1'b0; lds = 1'b1; data_write = {8'h00, tv[i].b};
      check($sformatf("tx%0d_ack_pre", i), ack, 1'b0);
      active_cnt = 0;
      for (int n = 0; n < 1200; n++) begin
        @(negedge clk);
        if (n == 0) begin
          check($sformatf("tx%0d_ack_rise", i), ack, 1'b1);
          check($sformatf("tx%0d_active_rise", i), tx_active, 1'b1);
        end
        if (n == 19) check($sformatf("tx%0d_ack_held", i), ack, 1'b1);
        if (n == 20) begin uds = 1'b0; lds = 1'b0; rw = 1'b1; end
        if (n == 300) begin
          addr = 2'd3; rw = 1'b0; lds = 1'b1; data_write = {8'h00, ~tv[i].b};
        end
        if (n == 305) begin uds = 1'b0; lds = 1'b0; rw = 1'b1; end
        if (tx_active) active_cnt++;
        if ((n % DIV) == DIV / 2 && n < 10 * DIV)
          check($sformatf("tx%0d_bit%0d", i, n / DIV), tx, tv[i].frame[n / DIV]);
      end
      check($sformatf("tx%0d_active_len", i), active_cnt, 1080);
      check($sformatf("tx%0d_idle_after", i), tx, 1'b1);
    end

    // Upper-byte-only tx write is ignored
    bus_write(2'd3, 1'b1, 1'b0, 16'h5500);
    repeat (5) @(negedge clk);
    check("uds_only_no_tx", tx_active, 1'b0);
    check("uds_only_tx_idle", tx, 1'b1);

    // Receive frames, read status and data, confirm flags cleared
    for (int i = 0; i < 4; i++) begin
      send_rx(rv[i].b, rv[i].stop);
      check($sformatf("rx%0d_avail", i), rx_avail, 1'b1);
      bus_read(2'd0, rd);
      check($sformatf("rx%0d_status", i), rd, rv[i].st);
      bus_read(2'd1, rd);
      check($sformatf("rx%0d_data", i), rd, rv[i].dat);
      bus_read(2'd0, rd);
      check($sformatf("rx%0d_status_clr", i), rd, 16'h0000);
    end

    // Overrun: two bytes without reading
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(2'd0, rd);
    check("ovr_status", rd, 16'h0006);
    bus_read(2'd1, rd);
    check("ovr_data", rd, 16'h0022);
    bus_read(2'd0, rd);
    check("ovr_status_clr", rd, 16'h0000);

    // One-cycle low glitch starts no frame
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    check("glitch_no_avail", rx_avail, 1'b0);
    bus_read(2'd0, rd);
    check("glitch_status", rd, 16'h0000);

    // rx_avail_clear_i holds rx_avail low but data still updates
    rx_avail_clear_i = 1'b1;
    send_rx(8'h33, 1'b1);
    check("clr_hold_avail", rx_avail, 1'b0);
    rx_avail_clear_i = 1'b0;
    @(negedge clk);
    check("clr_release_avail", rx_avail, 1'b0);
    bus_read(2'd1, rd);
    check("clr_data", rd, 16'h0033);

    // Read strobes every other cycle, both phases, across a byte completion
    for (int ph = 0; ph < 2; ph++) begin
      seen = 1'b0;
      tog  = ph[0];
      cnt  = 0;
      fork
        send_rx(8'h6C + 8'(ph), 1'b1);
        begin
          while (!seen && cnt < 12 * DIV) begin
            @(negedge clk);
            cnt++;
            if (rx_avail) begin
              seen = 1'b1; uds = 1'b0; lds = 1'b0;
            end else begin
              addr = 2'd1; rw = 1'b1; uds = 1'b0; lds = tog; tog = ~tog;
            end
          end
          uds = 1'b0; lds = 1'b0;
        end
      join
      check($sformatf("sim%0d_avail_kept", ph), seen, 1'b1);
      bus_read(2'd1, rd);
      check($sformatf("sim%0d_data", ph), rd, 16'h006C + 16'(ph));
      bus_read(2'd0, rd);
      check($sformatf("sim%0d_status_clr", ph), rd, 16'h0000);
    end

    // Reset in the middle of a transmit frame
    bus_write(2'd3, 1'b0, 1'b1, 16'h0000);
    repeat (300) @(negedge clk);
    check("midrst_active_before", tx_active, 1'b1);
    check("midrst_tx_low_before", tx, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_tx", tx, 1'b1);
    check("midrst_active", tx_active, 1'b0);
    seen = 1'b0;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_active !== 1'b0) seen = 1'b1;
    end
    check("midrst_stays_idle", seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
